wide_add_sequencer: RTL and testbench

Multi-cycle controller that computes W = 16×SLICES-bit add/subtract operations on one shared 16-bit carry-bypass adder. The adder is time-multiplexed one 16-bit slice per cycle, LSB slice first, with the slice carry registered between cycles. Operands arrive and results leave over valid/ready handshakes. It sits between an operand producer and a result consumer wherever wide arithmetic is needed without widening the adder datapath.

---
 rtl/wide_add_pkg.sv | 17 +
 rtl/wide_add_sequencer_if.sv | 31 +++
 rtl/wide_add_sequencer_cba.sv | 34 +++
 rtl/wide_add_sequencer.sv | 124 ++++++++++++
 tb/tb_wide_add_sequencer.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and constants for the time-multiplexed wide adder.
package wide_add_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice index width; never below one bit.
    function automatic int unsigned idx_w(input int unsigned slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/wide_add_sequencer_if.sv
// Operand/result handshake bundle for wide_add_sequencer.
interface wide_add_sequencer_if #(
    parameter int unsigned SLICES = 4
);
    localparam int unsigned W = wide_add_pkg::SLICE_W * SLICES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    // master: operand producer / result consumer side
    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    // slave: the sequencer
    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

endinterface

// File: rtl/wide_add_sequencer_cba.sv
// 16-bit carry-bypass adder: 4-bit ripple blocks whose carry skips a fully propagating block.
module top_carry_bypass_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    localparam int unsigned BLK_W = 4;
    localparam int unsigned N_BLK = 16 / BLK_W;

    always_comb begin
        logic c_blk;
        logic c_rip;
        logic prop;
        sum   = '0;
        c_blk = cin;
        c_rip = 1'b0;
        prop  = 1'b0;
        for (int blk = 0; blk < N_BLK; blk++) begin
            prop  = &(a[blk*BLK_W +: BLK_W] ^ b[blk*BLK_W +: BLK_W]);
            c_rip = c_blk;
            for (int i = 0; i < BLK_W; i++) begin
                sum[blk*BLK_W + i] = a[blk*BLK_W + i] ^ b[blk*BLK_W + i] ^ c_rip;
                c_rip = (a[blk*BLK_W + i] & b[blk*BLK_W + i]) |
                        (c_rip & (a[blk*BLK_W + i] ^ b[blk*BLK_W + i]));
            end
            // A fully propagating block passes its carry-in straight through.
            c_blk = prop ? c_blk : c_rip;
        end
        cout = c_blk;
    end

endmodule

// File: rtl/wide_add_sequencer.sv
// W-bit add/subtract computed one 16-bit slice per cycle on a single shared adder.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int unsigned SLICES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    wide_add_sequencer_if.slave  bus
);
    localparam int unsigned W     = SLICE_W * SLICES;
    localparam int unsigned IDX_W = idx_w(SLICES);

    state_e             state_q,     state_d;
    logic [W-1:0]       a_q,         a_d;
    logic [W-1:0]       b_q,         b_d;
    logic [W-1:0]       sum_q,       sum_d;
    logic               carry_q,     carry_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               cout_q,      cout_d;
    logic               ovf_q,       ovf_d;

    logic [SLICE_W-1:0] add_a_c;
    logic [SLICE_W-1:0] add_b_c;
    logic [SLICE_W-1:0] add_sum_c;
    logic               add_cout_c;
    logic               last_c;

    // Slice operand muxes feeding the shared adder.
    assign add_a_c = a_q[SLICE_W * 32'(idx_q) +: SLICE_W];
    assign add_b_c = b_q[SLICE_W * 32'(idx_q) +: SLICE_W];
    assign last_c  = (idx_q == IDX_W'(SLICES - 1));

    top_carry_bypass_adder u_adder (
        .a    (add_a_c),
        .b    (add_b_c),
        .cin  (carry_q),
        .sum  (add_sum_c),
        .cout (add_cout_c)
    );

    // Next-state and next-register logic.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        idx_d     = idx_q;
        cout_d    = cout_q;
        ovf_d     = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                    carry_d = bus.in_sub ? 1'b1 : bus.in_cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[SLICE_W * 32'(idx_q) +: SLICE_W] = add_sum_c;
                carry_d = add_cout_c;
                idx_d   = idx_q + IDX_W'(1);
                if (last_c) begin
                    idx_d   = '0;
                    cout_d  = add_cout_c;
                    // Like-signed operands whose result sign flips overflowed.
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum_c[SLICE_W-1] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_q;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Directed bench for wide_add_sequencer with a result scoreboard.
module tb_wide_add_sequencer;
    import wide_add_pkg::*;

    localparam int unsigned SLICES = 4;
    localparam int unsigned W      = 64;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n;

    wide_add_sequencer_if #(.SLICES(SLICES)) bus ();

    wide_add_sequencer #(.SLICES(SLICES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    res_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Reference result via wide signed arithmetic, independent of slicing.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t              r;
        logic [W-1:0]      bb;
        logic              c;
        logic [W:0]        u;
        logic signed [W+1:0] s;
        bb    = sub ? ~b : b;
        c     = sub ? 1'b1 : cin;
        u     = {1'b0, a} + {1'b0, bb} + (W+1)'(c);
        s     = $signed({{2{a[W-1]}}, a}) + $signed({{2{bb[W-1]}}, bb}) + $signed({{(W+1){1'b0}}, c});
        r.sum  = u[W-1:0];
        r.cout = u[W];
        r.ovf  = (s[W] != s[W-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic sub, input bit push);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_sub   = sub;
        bus.in_valid = 1'b1;
        if (push) sb.push_back(model(a, b, cin, sub));
    endtask

    // Returns at the negedge just after the acceptance edge.
    task automatic wait_accept(input string tag);
        int n = 0;
        while (!bus.in_ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_accept_timeout"}, W'(n < 30), W'(1));
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, W'(lat), W'(SLICES));
    endtask

    task automatic check_result(input string tag);
        res_t e;
        chk({tag, "_sb_nonempty"}, W'(sb.size() != 0), W'(1));
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_sum"},  bus.out_sum,  e.sum);
            chk({tag, "_cout"}, W'(bus.out_cout), W'(e.cout));
            chk({tag, "_ovf"},  W'(bus.out_ovf),  W'(e.ovf));
        end
    endtask

    task automatic wait_result(input string tag);
        wait_valid(tag);
        check_result(tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({tag, "_valid_drop"}, W'(bus.out_valid), W'(0));
        chk({tag, "_idle_ready"}, W'(bus.in_ready),  W'(1));
        bus.out_ready = 1'b0;
    endtask

    initial begin
        res_t held;
        int   seen_valid;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 3; i++) begin
            bus.in_valid  = 1'($urandom);
            bus.in_a      = {$urandom, $urandom};
            bus.in_b      = {$urandom, $urandom};
            bus.in_cin    = 1'($urandom);
            bus.in_sub    = 1'($urandom);
            bus.out_ready = 1'($urandom);
            @(negedge clk);
            chk("rst_out_valid", W'(bus.out_valid), W'(0));
            chk("rst_out_sum",   bus.out_sum,       W'(0));
            chk("rst_out_cout",  W'(bus.out_cout),  W'(0));
            chk("rst_out_ovf",   W'(bus.out_ovf),   W'(0));
            chk("rst_in_ready",  W'(bus.in_ready),  W'(1));
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_in_ready", W'(bus.in_ready), W'(1));
        end

        // Inter-slice carry
        drive_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
        wait_accept("carry");
        wait_result("carry");
        chk("carry_sum_const", bus.out_sum, 64'h0000_0000_0001_0000);

        // Full wrap
        drive_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b1);
        wait_accept("wrap");
        wait_result("wrap");

        // Back-to-back subtract then signed overflow
        drive_op(64'd5, 64'd7, 1'b0, 1'b1, 1'b1);
        wait_accept("sub");
        wait_result("sub");
        drive_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
        wait_accept("ovf");
        wait_result("ovf");

        // Backpressure with pending operands
        drive_op(64'h1111_2222_3333_4444, 64'h2222_3333_4444_CCCC, 1'b1, 1'b0, 1'b1);
        wait_accept("bp1");
        wait_valid("bp1");
        held = sb[0];
        check_result("bp1");
        drive_op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_in_ready",  W'(bus.in_ready),  W'(0));
            chk("bp_out_valid", W'(bus.out_valid), W'(1));
            chk("bp_sum_held",  bus.out_sum,       held.sum);
            chk("bp_cout_held", W'(bus.out_cout),  W'(held.cout));
            chk("bp_ovf_held",  W'(bus.out_ovf),   W'(held.ovf));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("bp_valid_drop", W'(bus.out_valid), W'(0));
        chk("bp_idle_ready", W'(bus.in_ready),  W'(1));
        @(negedge clk);
        chk("bp_pending_accepted", W'(bus.in_ready), W'(0));
        bus.in_valid = 1'b0;
        wait_result("bp2");

        // Reset in the middle of RUN
        drive_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0, 1'b0);
        wait_accept("midrun");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrun_sum_zero",  bus.out_sum,       W'(0));
        chk("midrun_valid",     W'(bus.out_valid), W'(0));
        chk("midrun_cout",      W'(bus.out_cout),  W'(0));
        chk("midrun_ovf",       W'(bus.out_ovf),   W'(0));
        chk("midrun_in_ready",  W'(bus.in_ready),  W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid++;
        end
        chk("midrun_no_result", W'(seen_valid), W'(0));
        drive_op(64'd1, 64'd2, 1'b0, 1'b0, 1'b1);
        wait_accept("after_rst");
        wait_result("after_rst");
        chk("after_rst_sum_const", bus.out_sum, W'(3));

        chk("sb_empty", W'(sb.size()), W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
